fir_64_driver: RTL and testbench
================================

Name: fir_64_driver

Overview:
Initiator/sequencer for the fir_64 operation bus; it is the host-side master that the filter responds to. It accepts one frame of SIGNAL_LENGTH 64-bit samples on a valid/ready input stream and clears the filter. It then writes the samples (operation 01), runs the computation (operation 10) until the filter's done rises, and reads the results back (operation 11) onto a valid/ready output stream. It sits between the streaming datapath and a fir_64 instance and owns that instance's reset.

Parameters:
SIGNAL_LENGTH, 1000, samples per frame; must match the filter's signalLength.
TIMEOUT_CYCLES, 1048576, maximum cycles spent in COMPUTE before an abort.

Ports:
clk  in  1  clock; all logic on its rising edge
reset  in  1  synchronous, active-high
start  in  1  single-cycle request to process one frame
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after the last output beat handshakes
timeout_err  out  1  sticky; set on COMPUTE timeout, cleared on the next accepted start
s_valid  in  1  input sample valid
s_ready  out  1  high only in LOAD
s_data  in  64  input sample
m_valid  out  1  output result valid
m_ready  in  1  downstream ready
m_data  out  64  output result
m_last  out  1  qualifies the final beat of a frame
fir_reset  out  1  drives the filter's reset
fir_addr  out  32  drives the filter's addr
fir_x  out  64  drives the filter's x
fir_op  out  2  drives the filter's operation: 00 idle, 01 write, 10 compute, 11 read
fir_y  in  64  filter result, valid the cycle after the filter samples a read
fir_done  in  1  filter completion flag; stays high until the filter is reset

Behaviour:
- All outputs are registered.
- Reset values: fir_reset=1; everything else 0 (busy, frame_done, timeout_err, s_ready, m_valid, m_data, m_last, fir_addr, fir_x, fir_op); state=IDLE; counters=0.
- reset asserted mid-operation: same values on the next edge. An in-flight m_valid beat is dropped. The filter is therefore cleared as well.
- IDLE: fir_reset<=0, fir_op<=00. On start: timeout_err<=0, busy<=1, state<=CLEAR.
- start is ignored in every state other than IDLE.
- CLEAR (exactly 1 cycle): fir_reset<=1, fir_op<=00. Next state LOAD with cnt=0, fir_reset<=0.
- LOAD: s_ready=1.
  - On handshake: fir_op<=01, fir_addr<=cnt, fir_x<=s_data for one cycle, cnt<=cnt+1.
  - Without a handshake: fir_op<=00.
  - Back-to-back beats are legal, giving one write per cycle.
  - On the handshake with cnt==SIGNAL_LENGTH-1: s_ready<=0, state<=COMPUTE, timer<=0.
- COMPUTE: fir_op<=10 on every edge; timer increments each cycle.
  - fir_done==1: fir_op<=00, k<=0, state<=READ_REQ.
  - timer==TIMEOUT_CYCLES-1 without fir_done: fir_op<=00, timeout_err<=1, busy<=0, state<=IDLE. frame_done does not pulse.
  - If fir_done and the timeout coincide, fir_done wins.
- Read sequence, 3 cycles per result, no pipelining:
  - READ_REQ: fir_op<=11, fir_addr<=k.
  - READ_WAIT: fir_op held at 11 while the filter registers y.
  - READ_CAP: m_data<=fir_y, m_last<=(k==SIGNAL_LENGTH-1), m_valid<=1, fir_op<=00, state<=OUT.
- OUT:
  - m_valid, m_data and m_last hold stable while !m_ready.
  - On handshake: m_valid<=0.
  - If the beat was last: frame_done<=1 for one cycle, busy<=0, state<=IDLE.
  - Otherwise: k<=k+1, state<=READ_REQ.
- Counters cnt and k are 32 bits, compared against SIGNAL_LENGTH-1. No wrap is possible within a frame.
- fir_x and fir_addr hold their last value when fir_op is not 01/11; their content is don't-care then.

Decomposition:
- Shared package: the fir operation encoding enum (FIR_OP_IDLE=00, WRITE=01, COMPUTE=10, READ=11), the driver state enum, and the 64-bit data typedef. fir_64 is to adopt the same encoding.
- No sub-module is needed; the optional timeout counter may be split out as fir_watchdog.

Test Plan:
- SIGNAL_LENGTH=4, stream samples 1,2,3,4 back-to-back -> one CLEAR pulse on fir_reset, then fir_op=01 with fir_addr 0..3 and fir_x 1..4 on consecutive cycles, then fir_op=10.
- Responder model raises fir_done 20 cycles into COMPUTE and returns outputs[k]=10*k+7 -> m_data 7,17,27,37 in order, m_last only on 37, frame_done pulses once, busy drops in the same cycle.
- m_ready held low 5 cycles on beat 2 -> m_valid and m_data=27 stable throughout; no extra fir_op=11 is issued until the handshake.
- TIMEOUT_CYCLES=16, fir_done never rises -> timeout_err=1 after 16 COMPUTE cycles, fir_op=00, busy=0, frame_done stays 0. A following start clears timeout_err.
- reset asserted during LOAD after 2 beats -> next cycle fir_reset=1, s_ready=0, busy=0. A new frame then completes normally from addr 0.
- start pulsed during OUT -> ignored; the frame completes with exactly 4 beats.

Source files
------------

// File: rtl/fir_64_driver_pkg.sv
// Shared encodings for the fir_64 operation bus and its host-side driver.
// The filter adopts the same operation enum so both ends agree on the wire values.
package fir_64_driver_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 32;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic [ADDR_W-1:0]        addr_t;

   typedef enum logic [1:0] {
      FIR_OP_IDLE    = 2'b00,
      FIR_OP_WRITE   = 2'b01,
      FIR_OP_COMPUTE = 2'b10,
      FIR_OP_READ    = 2'b11
   } fir_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_COMPUTE,
      ST_READ_REQ,
      ST_READ_WAIT,
      ST_READ_CAP,
      ST_OUT
   } drv_state_e;

endpackage

// File: rtl/fir_64_driver_if.sv
// fir_64 operation bus: the driver is the master, the filter instance is the slave.
interface fir_64_driver_if;
   import fir_64_driver_pkg::*;

   logic    fir_reset;
   addr_t   fir_addr;
   sample_t fir_x;
   fir_op_e fir_op;
   sample_t fir_y;
   logic    fir_done;

   modport master (
      output fir_reset, fir_addr, fir_x, fir_op,
      input  fir_y, fir_done
   );

   modport slave (
      input  fir_reset, fir_addr, fir_x, fir_op,
      output fir_y, fir_done
   );

endinterface

// File: rtl/fir_64_driver.sv
// Host-side sequencer for one fir_64 instance: clear, load a frame, compute,
// then read the results back one beat at a time onto the output stream.
module fir_64_driver
   import fir_64_driver_pkg::*;
#(
   parameter int SIGNAL_LENGTH  = 1000,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            frame_done,
   output logic            timeout_err,
   input  logic            s_valid,
   output logic            s_ready,
   input  sample_t         s_data,
   output logic            m_valid,
   input  logic            m_ready,
   output sample_t         m_data,
   output logic            m_last,
   fir_64_driver_if.master fir
);

   localparam addr_t LAST_IDX     = addr_t'(SIGNAL_LENGTH - 1);
   localparam addr_t TIMEOUT_LAST = addr_t'(TIMEOUT_CYCLES - 1);

   drv_state_e state_q, state_d;
   addr_t      cnt_q, cnt_d, k_q, k_d, timer_q, timer_d;
   logic       busy_q, busy_d, frame_done_q, frame_done_d, timeout_err_q, timeout_err_d;
   logic       s_ready_q, s_ready_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
   sample_t    m_data_q, m_data_d, fir_x_q, fir_x_d;
   logic       fir_reset_q, fir_reset_d;
   addr_t      fir_addr_q, fir_addr_d;
   fir_op_e    fir_op_q, fir_op_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         k_q           <= '0;
         timer_q       <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         s_ready_q     <= 1'b0;
         m_valid_q     <= 1'b0;
         m_data_q      <= '0;
         m_last_q      <= 1'b0;
         fir_reset_q   <= 1'b1;
         fir_addr_q    <= '0;
         fir_x_q       <= '0;
         fir_op_q      <= FIR_OP_IDLE;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         k_q           <= k_d;
         timer_q       <= timer_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         timeout_err_q <= timeout_err_d;
         s_ready_q     <= s_ready_d;
         m_valid_q     <= m_valid_d;
         m_data_q      <= m_data_d;
         m_last_q      <= m_last_d;
         fir_reset_q   <= fir_reset_d;
         fir_addr_q    <= fir_addr_d;
         fir_x_q       <= fir_x_d;
         fir_op_q      <= fir_op_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      k_d           = k_q;
      timer_d       = timer_q;
      busy_d        = busy_q;
      frame_done_d  = 1'b0;
      timeout_err_d = timeout_err_q;
      s_ready_d     = s_ready_q;
      m_valid_d     = m_valid_q;
      m_data_d      = m_data_q;
      m_last_d      = m_last_q;
      fir_reset_d   = fir_reset_q;
      fir_addr_d    = fir_addr_q;
      fir_x_d       = fir_x_q;
      fir_op_d      = fir_op_q;

      case (state_q)
         ST_IDLE: begin
            fir_reset_d = 1'b0;
            fir_op_d    = FIR_OP_IDLE;
            if (start) begin
               timeout_err_d = 1'b0;
               busy_d        = 1'b1;
               state_d       = ST_CLEAR;
            end
         end
         // One-cycle filter reset; s_ready rises together with it.
         ST_CLEAR: begin
            fir_reset_d = 1'b1;
            fir_op_d    = FIR_OP_IDLE;
            cnt_d       = '0;
            s_ready_d   = 1'b1;
            state_d     = ST_LOAD;
         end
         ST_LOAD: begin
            fir_reset_d = 1'b0;
            if (s_valid && s_ready_q) begin
               fir_op_d   = FIR_OP_WRITE;
               fir_addr_d = cnt_q;
               fir_x_d    = s_data;
               cnt_d      = cnt_q + addr_t'(1);
               if (cnt_q == LAST_IDX) begin
                  s_ready_d = 1'b0;
                  timer_d   = '0;
                  state_d   = ST_COMPUTE;
               end
            end else begin
               fir_op_d = FIR_OP_IDLE;
            end
         end
         // fir_done is checked first so it wins over a coincident timeout.
         ST_COMPUTE: begin
            fir_op_d = FIR_OP_COMPUTE;
            timer_d  = timer_q + addr_t'(1);
            if (fir.fir_done) begin
               fir_op_d = FIR_OP_IDLE;
               k_d      = '0;
               state_d  = ST_READ_REQ;
            end else if (timer_q == TIMEOUT_LAST) begin
               fir_op_d      = FIR_OP_IDLE;
               timeout_err_d = 1'b1;
               busy_d        = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         ST_READ_REQ: begin
            fir_op_d   = FIR_OP_READ;
            fir_addr_d = k_q;
            state_d    = ST_READ_WAIT;
         end
         ST_READ_WAIT: begin
            state_d = ST_READ_CAP;
         end
         ST_READ_CAP: begin
            m_data_d  = fir.fir_y;
            m_last_d  = (k_q == LAST_IDX);
            m_valid_d = 1'b1;
            fir_op_d  = FIR_OP_IDLE;
            state_d   = ST_OUT;
         end
         ST_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               if (m_last_q) begin
                  frame_done_d = 1'b1;
                  busy_d       = 1'b0;
                  state_d      = ST_IDLE;
               end else begin
                  k_d     = k_q + addr_t'(1);
                  state_d = ST_READ_REQ;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy          = busy_q;
   assign frame_done    = frame_done_q;
   assign timeout_err   = timeout_err_q;
   assign s_ready       = s_ready_q;
   assign m_valid       = m_valid_q;
   assign m_data        = m_data_q;
   assign m_last        = m_last_q;
   assign fir.fir_reset = fir_reset_q;
   assign fir.fir_addr  = fir_addr_q;
   assign fir.fir_x     = fir_x_q;
   assign fir.fir_op    = fir_op_q;

endmodule

// File: tb/tb_fir_64_driver.sv
// Directed bench for fir_64_driver with a small behavioural fir_64 responder.
module tb_fir_64_driver;
   import fir_64_driver_pkg::*;

   localparam int SL = 4;
   localparam int TO = 24;

   logic    clk = 1'b0;
   logic    reset, start, s_valid, m_ready;
   logic    busy, frame_done, timeout_err, s_ready, m_valid, m_last;
   sample_t s_data, m_data;

   int vectors = 0;
   int miscompares = 0;
   int done_after = 0;
   int ccount;
   logic [63:0] mem [0:SL-1];

   fir_64_driver_if bus ();

   fir_64_driver #(.SIGNAL_LENGTH(SL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .frame_done(frame_done), .timeout_err(timeout_err),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .fir(bus.master)
   );

   always #5 clk = ~clk;

   // Responder: done rises after done_after compute cycles (0 = never), y = 10*addr+7.
   always @(posedge clk) begin
      if (bus.fir_reset) begin
         bus.fir_done <= 1'b0;
         ccount       <= 0;
      end else begin
         case (bus.fir_op)
            FIR_OP_WRITE:   mem[bus.fir_addr[1:0]] <= bus.fir_x;
            FIR_OP_COMPUTE: begin
               ccount <= ccount + 1;
               if (done_after != 0 && ccount + 1 == done_after) bus.fir_done <= 1'b1;
            end
            FIR_OP_READ:    bus.fir_y <= sample_t'(64'(10 * int'(bus.fir_addr) + 7));
            default: ;
         endcase
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", 64'(busy), 64'd1);
      check("start_terr", 64'(timeout_err), 64'd0);
      tick();
      check("clear_rst", 64'(bus.fir_reset), 64'd1);
      check("clear_rdy", 64'(s_ready), 64'd1);
   endtask

   task automatic load(input int n, input logic [63:0] base);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = sample_t'(base + 64'(i));
         tick();
         check("ld_op", 64'(bus.fir_op), 64'(FIR_OP_WRITE));
         check("ld_addr", 64'(bus.fir_addr), 64'(i));
         check("ld_x", 64'(bus.fir_x), base + 64'(i));
         check("ld_rst", 64'(bus.fir_reset), 64'd0);
      end
      s_valid = 1'b0;
   endtask

   task automatic enter_compute();
      check("ld_end_rdy", 64'(s_ready), 64'd0);
      tick();
      check("cmp_op", 64'(bus.fir_op), 64'(FIR_OP_COMPUTE));
   endtask

   task automatic await_beat(input int k, output int lat);
      lat = 0;
      while (!m_valid && lat < 200) begin
         if (bus.fir_op == FIR_OP_READ) check("rd_addr", 64'(bus.fir_addr), 64'(k));
         tick();
         lat++;
      end
      check("beat_seen", 64'(m_valid), 64'd1);
   endtask

   task automatic take_beat(input int k, input int hold, input bit pulse_start);
      int lat;
      await_beat(k, lat);
      for (int h = 0; h < hold; h++) begin
         m_ready = 1'b0;
         tick();
         check("hold_valid", 64'(m_valid), 64'd1);
         check("hold_data", 64'(m_data), 64'(10 * k + 7));
         check("hold_op", 64'(bus.fir_op), 64'(FIR_OP_IDLE));
      end
      check("beat_data", 64'(m_data), 64'(10 * k + 7));
      check("beat_last", 64'(m_last), 64'(k == SL - 1));
      if (pulse_start) start = 1'b1;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      start   = 1'b0;
      check("hs_valid", 64'(m_valid), 64'd0);
      check("hs_fdone", 64'(frame_done), 64'(k == SL - 1));
      check("hs_busy", 64'(busy), 64'(k != SL - 1));
   endtask

   task automatic read_frame(input int hold_k, input int start_k);
      for (int k = 0; k < SL; k++) take_beat(k, (k == hold_k) ? 5 : 0, k == start_k);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_fdone", 64'(frame_done), 64'd0);
         check("post_busy", 64'(busy), 64'd0);
         check("post_valid", 64'(m_valid), 64'd0);
      end
   endtask

   initial begin
      int lat;
      reset = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      tick();
      tick();
      check("rst_fir_reset", 64'(bus.fir_reset), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_op", 64'(bus.fir_op), 64'(FIR_OP_IDLE));
      check("rst_ready", 64'(s_ready), 64'd0);
      check("rst_mvalid", 64'(m_valid), 64'd0);
      check("rst_terr", 64'(timeout_err), 64'd0);
      check("rst_fdone", 64'(frame_done), 64'd0);
      reset = 1'b0;
      tick();
      check("idle_fir_reset", 64'(bus.fir_reset), 64'd0);

      // Normal frame, beat 2 stalled for 5 cycles.
      done_after = 20;
      start_frame();
      load(SL, 64'd1);
      enter_compute();
      await_beat(0, lat);
      check("lat_done20", 64'(lat), 64'd24);
      read_frame(2, -1);
      for (int i = 0; i < SL; i++) check("mem_f1", mem[i], 64'(i + 1));

      // done arrives exactly on the last timeout cycle; start pulsed during OUT.
      done_after = TO - 2;
      start_frame();
      load(SL, 64'h10);
      enter_compute();
      await_beat(0, lat);
      check("lat_coincide", 64'(lat), 64'(TO + 2));
      check("coincide_terr", 64'(timeout_err), 64'd0);
      read_frame(-1, 1);

      // done never rises: abort after TO compute cycles.
      done_after = 0;
      start_frame();
      load(SL, 64'h20);
      enter_compute();
      repeat (TO - 2) tick();
      check("to_pre_busy", 64'(busy), 64'd1);
      check("to_pre_terr", 64'(timeout_err), 64'd0);
      check("to_pre_op", 64'(bus.fir_op), 64'(FIR_OP_COMPUTE));
      tick();
      check("to_terr", 64'(timeout_err), 64'd1);
      check("to_busy", 64'(busy), 64'd0);
      check("to_op", 64'(bus.fir_op), 64'(FIR_OP_IDLE));
      check("to_fdone", 64'(frame_done), 64'd0);
      tick();
      check("to_sticky", 64'(timeout_err), 64'd1);
      check("to_fdone2", 64'(frame_done), 64'd0);

      // Next start clears timeout_err; reset hits mid-LOAD after 2 beats.
      start_frame();
      load(2, 64'h30);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_fir_reset", 64'(bus.fir_reset), 64'd1);
      check("mid_ready", 64'(s_ready), 64'd0);
      check("mid_busy", 64'(busy), 64'd0);
      check("mid_op", 64'(bus.fir_op), 64'(FIR_OP_IDLE));
      tick();
      check("mid_idle_rst", 64'(bus.fir_reset), 64'd0);

      // Fresh frame after the abort restarts from address 0.
      done_after = 20;
      start_frame();
      load(SL, 64'h100);
      enter_compute();
      await_beat(0, lat);
      check("lat_after_rst", 64'(lat), 64'd24);
      read_frame(-1, -1);
      for (int i = 0; i < SL; i++) check("mem_f5", mem[i], 64'h100 + 64'(i));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
